// File: rtl/ptr_sync_flag_gen.sv
// Gray pointer synchroniser for async FIFOs: N-flop sync, Gray->binary, registered level and flags.
// Define PTR_SYNC_GRAY_CHECK_EN to build the sticky Gray-coding violation monitor on o_gray_err.
module ptr_sync_flag_gen #(
  parameter int unsigned PTR_W     = 12,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned SIDE      = 0,
  parameter int unsigned ALMOST_TH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [PTR_W:0] i_remote_gptr,
  input  logic [PTR_W:0] i_local_bptr,
  output logic [PTR_W:0] o_remote_gptr,
  output logic [PTR_W:0] o_remote_bptr,
  output logic [PTR_W:0] o_level,
  output logic           o_flag,
  output logic           o_almost,
  output logic           o_sync_valid,
  output logic           o_gray_err
);

  localparam int unsigned PW       = PTR_W + 1;
  localparam int unsigned WARM_MAX = STAGES + 1;
  localparam int unsigned CNT_W    = $clog2(WARM_MAX + 1);

  localparam logic [PTR_W:0]   FULL_LVL   = {1'b1, {PTR_W{1'b0}}};
  localparam logic [PTR_W:0]   AFULL_LVL  = FULL_LVL - PW'(ALMOST_TH);
  localparam logic [PTR_W:0]   AEMPTY_LVL = PW'(ALMOST_TH);
  localparam logic [CNT_W-1:0] WARM_DONE  = CNT_W'(WARM_MAX);

  // Elaboration-time parameter legality
  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("ptr_sync_flag_gen: STAGES must be in 2..4");
    end
    if (SIDE > 1) begin : g_bad_side
      $error("ptr_sync_flag_gen: SIDE must be 0 or 1");
    end
    if (ALMOST_TH < 1 || ALMOST_TH > ((1 << PTR_W) - 1)) begin : g_bad_th
      $error("ptr_sync_flag_gen: ALMOST_TH must be in 1..2^PTR_W-1");
    end
  endgenerate

  logic [STAGES-1:0][PTR_W:0] sync_q, sync_d;
  logic [PTR_W:0]             bptr_q, bptr_d;
  logic [PTR_W:0]             level_q, level_d;
  logic                       flag_q, flag_d;
  logic                       almost_q, almost_d;
  logic [CNT_W-1:0]           warm_q, warm_d;
  logic                       valid_q, valid_d;

  logic [PTR_W:0] gptr_c;
  logic [PTR_W:0] raw_lvl_c;
  logic           full_c, afull_c, empty_c, aempty_c;

  assign gptr_c = sync_q[STAGES-1];

  // Plain shift chain; stage 0 is the only flop that sees the asynchronous input
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_remote_gptr};
  end

  // Gray->binary: bit i is the XOR of all Gray bits at or above i
  always_comb begin
    bptr_d = gptr_c;
    for (int unsigned s = 1; s < PW; s++) begin
      bptr_d = bptr_d ^ (gptr_c >> s);
    end
  end

  // Modulo subtraction handles pointer wrap without special cases
  always_comb begin
    if (SIDE == 0) begin
      raw_lvl_c = i_local_bptr - bptr_q;
    end else begin
      raw_lvl_c = bptr_q - i_local_bptr;
    end
  end

  always_comb begin
    full_c   = (raw_lvl_c >= FULL_LVL);
    afull_c  = (raw_lvl_c >= AFULL_LVL);
    empty_c  = (raw_lvl_c == '0);
    aempty_c = (raw_lvl_c <= AEMPTY_LVL);
  end

  // Until the chain carries post-reset data, report the conservative state
  always_comb begin
    level_d  = '0;
    flag_d   = 1'b1;
    almost_d = 1'b1;
    if (valid_q) begin
      level_d  = raw_lvl_c;
      flag_d   = (SIDE == 0) ? full_c  : empty_c;
      almost_d = (SIDE == 0) ? afull_c : aempty_c;
    end
  end

  always_comb begin
    warm_d  = (warm_q == WARM_DONE) ? warm_q : warm_q + CNT_W'(1);
    valid_d = (warm_d == WARM_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q   <= '0;
      bptr_q   <= '0;
      level_q  <= '0;
      flag_q   <= 1'b1;
      almost_q <= 1'b0;
      warm_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      bptr_q   <= bptr_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
      warm_q   <= warm_d;
      valid_q  <= valid_d;
    end
  end

  assign o_remote_gptr = gptr_c;
  assign o_remote_bptr = bptr_q;
  assign o_level       = level_q;
  assign o_flag        = flag_q;
  assign o_almost      = almost_q;
  assign o_sync_valid  = valid_q;

`ifdef PTR_SYNC_GRAY_CHECK_EN
  logic [PTR_W:0] gprev_q;
  logic [PTR_W:0] gdiff_c;
  logic           gerr_q, gerr_d;

  // A legal Gray step flips at most one bit: x & (x-1) != 0 means two or more
  always_comb begin
    gdiff_c = gptr_c ^ gprev_q;
    gerr_d  = gerr_q | (valid_q && ((gdiff_c & (gdiff_c - PW'(1))) != '0));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gprev_q <= '0;
      gerr_q  <= 1'b0;
    end else begin
      gprev_q <= gptr_c;
      gerr_q  <= gerr_d;
    end
  end

  assign o_gray_err = gerr_q;
`else
  assign o_gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_sync_flag_gen.sv
// Bench for ptr_sync_flag_gen: write- and read-side instances share pointer stimulus; per-cycle
// expectations from an input-history model are queued and checked by a negedge monitor.
module tb_ptr_sync_flag_gen;

  localparam int PTR_W = 4;
  localparam int ST    = 2;
  localparam int AT    = 4;
  localparam int PW    = PTR_W + 1;
  localparam int MOD   = 1 << PW;
  localparam int DEPTH = 1 << PTR_W;

  typedef struct packed {
    logic [PTR_W:0] gptr;
    logic [PTR_W:0] bptr;
    logic [PTR_W:0] lvl_w;
    logic [PTR_W:0] lvl_r;
    logic           flag_w;
    logic           alm_w;
    logic           flag_r;
    logic           alm_r;
    logic           valid;
    logic           err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [PTR_W:0] rem_g;
  logic [PTR_W:0] loc_b;

  logic [PTR_W:0] w_gptr, w_bptr, w_lvl, r_gptr, r_bptr, r_lvl;
  logic           w_flag, w_alm, w_valid, w_err, r_flag, r_alm, r_valid, r_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Model state: edges since reset release plus every sample taken since then
  int   n = 0;
  int   rem_h[$];
  int   loc_h[$];
  bit   err_m = 1'b0;

  always #5 clk = ~clk;

  ptr_sync_flag_gen #(.PTR_W(PTR_W), .STAGES(ST), .SIDE(0), .ALMOST_TH(AT)) u_wr (
    .i_clk(clk), .i_rst(rst), .i_remote_gptr(rem_g), .i_local_bptr(loc_b),
    .o_remote_gptr(w_gptr), .o_remote_bptr(w_bptr), .o_level(w_lvl), .o_flag(w_flag),
    .o_almost(w_alm), .o_sync_valid(w_valid), .o_gray_err(w_err)
  );

  ptr_sync_flag_gen #(.PTR_W(PTR_W), .STAGES(ST), .SIDE(1), .ALMOST_TH(AT)) u_rd (
    .i_clk(clk), .i_rst(rst), .i_remote_gptr(rem_g), .i_local_bptr(loc_b),
    .o_remote_gptr(r_gptr), .o_remote_bptr(r_bptr), .o_level(r_lvl), .o_flag(r_flag),
    .o_almost(r_alm), .o_sync_valid(r_valid), .o_gray_err(r_err)
  );

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & (MOD - 1);
  endfunction

  // Inverse Gray by search over the code space
  function automatic int g2b(input int g);
    for (int b = 0; b < MOD; b++) begin
      if (b2g(b) == g) return b;
    end
    return 0;
  endfunction

  function automatic int rem_at(input int m);
    if (m < 1 || m > rem_h.size()) return 0;
    return rem_h[m-1];
  endfunction

  function automatic void model_step(input bit r, input int g, input int lb);
    if (r) begin
      n = 0;
      rem_h.delete();
      loc_h.delete();
      err_m = 1'b0;
    end else begin
      n++;
      rem_h.push_back(g);
      loc_h.push_back(lb);
`ifdef PTR_SYNC_GRAY_CHECK_EN
      if ((n - 1) >= ST + 1 && $countones(rem_at(n - ST) ^ rem_at(n - 1 - ST)) > 1) err_m = 1'b1;
`endif
    end
  endfunction

  function automatic exp_t model_out(input bit rst_now);
    exp_t e;
    bit   pv;
    int   pb, lv, lw, lr;
    e        = '0;
    e.flag_w = 1'b1;
    e.flag_r = 1'b1;
    if (rst_now || n == 0) return e;
    e.gptr  = PW'(rem_at(n - ST + 1));
    e.bptr  = PW'(g2b(rem_at(n - ST)));
    e.valid = (n >= ST + 1);
    e.err   = err_m;
    pv = ((n - 1) >= ST + 1);
    pb = g2b(rem_at(n - 1 - ST));
    lv = loc_h[n-1];
    lw = (lv - pb + MOD) % MOD;
    lr = (pb - lv + MOD) % MOD;
    if (pv) begin
      e.lvl_w  = PW'(lw);
      e.lvl_r  = PW'(lr);
      e.flag_w = (lw >= DEPTH);
      e.alm_w  = (lw >= DEPTH - AT);
      e.flag_r = (lr == 0);
      e.alm_r  = (lr <= AT);
    end else begin
      e.alm_w = 1'b1;
      e.alm_r = 1'b1;
    end
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endfunction

  // Called just after a rising edge: drive inputs, queue what the next falling edge must show
  task automatic cycle(input bit r, input int g, input int lb);
    rst   = r;
    rem_g = PW'(g & (MOD - 1));
    loc_b = PW'(lb & (MOD - 1));
    exp_q.push_back(model_out(r));
    @(posedge clk);
    model_step(r, g & (MOD - 1), lb & (MOD - 1));
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("wr_gptr",   32'(w_gptr),  32'(mon_e.gptr));
      chk("wr_bptr",   32'(w_bptr),  32'(mon_e.bptr));
      chk("wr_level",  32'(w_lvl),   32'(mon_e.lvl_w));
      chk("wr_full",   32'(w_flag),  32'(mon_e.flag_w));
      chk("wr_afull",  32'(w_alm),   32'(mon_e.alm_w));
      chk("wr_valid",  32'(w_valid), 32'(mon_e.valid));
      chk("wr_grayerr",32'(w_err),   32'(mon_e.err));
      chk("rd_gptr",   32'(r_gptr),  32'(mon_e.gptr));
      chk("rd_bptr",   32'(r_bptr),  32'(mon_e.bptr));
      chk("rd_level",  32'(r_lvl),   32'(mon_e.lvl_r));
      chk("rd_empty",  32'(r_flag),  32'(mon_e.flag_r));
      chk("rd_aempty", 32'(r_alm),   32'(mon_e.alm_r));
      chk("rd_valid",  32'(r_valid), 32'(mon_e.valid));
      chk("rd_grayerr",32'(r_err),   32'(mon_e.err));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, lb, inj;
    rst   = 1'b1;
    rem_g = '0;
    loc_b = '0;
    @(posedge clk);
    #1;

    // Reset held, then warm-up
    repeat (3) cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);

    // Remote 0 -> 1 with local 0 (illegal level 31), then local 0x11
    repeat (5) cycle(0, b2g(1), 0);
    repeat (3) cycle(0, b2g(1), 5'h11);

    // Full / almost-full approach, then remote advance drops below full
    repeat (5) cycle(0, b2g(0), 11);
    repeat (2) cycle(0, b2g(0), 12);
    repeat (2) cycle(0, b2g(0), 16);
    repeat (5) cycle(0, b2g(1), 16);

    // Read-side wrap: remote 2, local 0x1E then 2
    repeat (5) cycle(0, b2g(2), 5'h1E);
    repeat (3) cycle(0, b2g(2), 2);

    // Reset mid-operation at write-side level 9
    repeat (4) cycle(0, b2g(2), 11);
    repeat (2) cycle(1, b2g(2), 11);
    repeat (6) cycle(0, b2g(2), 11);

    // Random legal traffic with occasional resets
    rb = 2;
    lb = 11;
    for (int i = 0; i < 400; i++) begin
      int  occ;
      int  op;
      bit  r;
      occ = (lb - rb + MOD) % MOD;
      op  = int'($urandom_range(0, 3));
      if ((op == 1 || op == 3) && occ > 0) rb = (rb + 1) % MOD;
      if ((op == 2 || op == 3) && occ < DEPTH) lb = (lb + 1) % MOD;
      r = ($urandom_range(0, 99) == 0);
      cycle(r, b2g(rb), lb);
    end

    // Two-bit Gray jump, then legal traffic: error must stick until reset
    repeat (6) cycle(0, b2g(rb), lb);
    inj = b2g(rb) ^ 5'b00101;
    repeat (4) cycle(0, inj, lb);
    rb = g2b(inj);
    for (int i = 0; i < 12; i++) begin
      rb = (rb + 1) % MOD;
      cycle(0, b2g(rb), lb);
    end
    repeat (2) cycle(1, b2g(rb), lb);
    repeat (6) cycle(0, b2g(rb), lb);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
